// File: rtl/mips_pkg.sv
// Shared MIPS-I front-end definitions: encodings, decoded-op codes, instruction classes and
// the decoded-instruction record passed from the decoder to the output registers.
package mips_pkg;

  localparam logic [31:0] START_ADDRESS_DEFAULT = 32'h8002_0000;
  localparam logic [1:0]  ACC_WORD              = 2'b00;

  localparam logic [5:0] OPC_SPECIAL = 6'h00, OPC_REGIMM = 6'h01, OPC_J     = 6'h02,
                         OPC_JAL     = 6'h03, OPC_BEQ    = 6'h04, OPC_BNE   = 6'h05,
                         OPC_BLEZ    = 6'h06, OPC_BGTZ   = 6'h07, OPC_ADDI  = 6'h08,
                         OPC_ADDIU   = 6'h09, OPC_SLTI   = 6'h0a, OPC_SLTIU = 6'h0b,
                         OPC_ANDI    = 6'h0c, OPC_ORI    = 6'h0d, OPC_XORI  = 6'h0e,
                         OPC_LUI     = 6'h0f, OPC_LB     = 6'h20, OPC_LH    = 6'h21,
                         OPC_LW      = 6'h23, OPC_LBU    = 6'h24, OPC_LHU   = 6'h25,
                         OPC_SB      = 6'h28, OPC_SH     = 6'h29, OPC_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA   = 6'h03, FN_SLLV  = 6'h04,
                         FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR    = 6'h08, FN_JALR  = 6'h09,
                         FN_MFHI = 6'h10, FN_MFLO = 6'h12, FN_MULT  = 6'h18, FN_MULTU = 6'h19,
                         FN_DIV  = 6'h1a, FN_DIVU = 6'h1b, FN_ADD   = 6'h20, FN_ADDU  = 6'h21,
                         FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND   = 6'h24, FN_OR    = 6'h25,
                         FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT   = 6'h2a, FN_SLTU  = 6'h2b;

  localparam logic [4:0] RT_BLTZ = 5'd0, RT_BGEZ = 5'd1;

  localparam logic [1:0] CLASS_R = 2'd0, CLASS_I = 2'd1, CLASS_J = 2'd2, CLASS_ILL = 2'd3;

  // OP_NOP must stay at code 0 so a cleared decode record reads as a NOP.
  typedef enum logic [5:0] {
    OP_NOP, OP_ILLEGAL,
    OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_JR, OP_JALR, OP_MFHI, OP_MFLO,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR,
    OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_BLTZ, OP_BGEZ,
    OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
    OP_XORI, OP_LUI, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_J, OP_JAL
  } op_e;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm_ext;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    op_e         op;
    logic [1:0]  insn_class;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/mips_fetch_decode_if.sv
// Memory-side fetch/instruction bus plus the decoded-instruction outputs of the front end.
interface mips_fetch_decode_if;
  import mips_pkg::*;

  logic [31:0] pc_out;
  logic        rw;
  logic [1:0]  acc_size_out;
  logic [31:0] insn;
  logic [31:0] pc_in;
  logic        valid_insn;

  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [31:0] imm_ext, br_target, jmp_target;
  op_e         op;
  logic [1:0]  insn_class;
  logic        illegal;

  modport master (
    output pc_out, rw, acc_size_out,
    input  insn, pc_in, valid_insn,
    output dec_valid, dec_pc, opcode, rs, rt, rd, shamt, funct, imm_ext, br_target, jmp_target,
    output op, insn_class, illegal
  );

  modport slave (
    input  pc_out, rw, acc_size_out,
    output insn, pc_in, valid_insn,
    input  dec_valid, dec_pc, opcode, rs, rt, rd, shamt, funct, imm_ext, br_target, jmp_target,
    input  op, insn_class, illegal
  );
endinterface

// File: rtl/mips_decoder.sv
// Combinational MIPS-I decoder: splits an instruction word into fields, classifies it and
// computes branch/jump targets relative to the PC it was fetched from.
module mips_decoder
  import mips_pkg::*;
(
  input  logic [31:0] insn,
  input  logic [31:0] pc,
  output dec_t        dec
);

  logic [31:0] sext_imm;
  logic [31:0] pc_plus4;
  op_e         op;

  assign sext_imm = {{16{insn[15]}}, insn[15:0]};
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    op = OP_ILLEGAL;
    if (insn == 32'd0) begin
      op = OP_NOP;
    end else begin
      case (insn[31:26])
        OPC_SPECIAL: begin
          case (insn[5:0])
            FN_SLL:  op = OP_SLL;   FN_SRL:   op = OP_SRL;   FN_SRA:  op = OP_SRA;
            FN_SLLV: op = OP_SLLV;  FN_SRLV:  op = OP_SRLV;  FN_SRAV: op = OP_SRAV;
            FN_JR:   op = OP_JR;    FN_JALR:  op = OP_JALR;  FN_MFHI: op = OP_MFHI;
            FN_MFLO: op = OP_MFLO;  FN_MULT:  op = OP_MULT;  FN_MULTU: op = OP_MULTU;
            FN_DIV:  op = OP_DIV;   FN_DIVU:  op = OP_DIVU;  FN_ADD:  op = OP_ADD;
            FN_ADDU: op = OP_ADDU;  FN_SUB:   op = OP_SUB;   FN_SUBU: op = OP_SUBU;
            FN_AND:  op = OP_AND;   FN_OR:    op = OP_OR;    FN_XOR:  op = OP_XOR;
            FN_NOR:  op = OP_NOR;   FN_SLT:   op = OP_SLT;   FN_SLTU: op = OP_SLTU;
            default: op = OP_ILLEGAL;
          endcase
        end
        OPC_REGIMM: begin
          case (insn[20:16])
            RT_BLTZ: op = OP_BLTZ;
            RT_BGEZ: op = OP_BGEZ;
            default: op = OP_ILLEGAL;
          endcase
        end
        OPC_J:    op = OP_J;     OPC_JAL:   op = OP_JAL;   OPC_BEQ:  op = OP_BEQ;
        OPC_BNE:  op = OP_BNE;   OPC_BLEZ:  op = OP_BLEZ;  OPC_BGTZ: op = OP_BGTZ;
        OPC_ADDI: op = OP_ADDI;  OPC_ADDIU: op = OP_ADDIU; OPC_SLTI: op = OP_SLTI;
        OPC_SLTIU: op = OP_SLTIU; OPC_ANDI: op = OP_ANDI;  OPC_ORI:  op = OP_ORI;
        OPC_XORI: op = OP_XORI;  OPC_LUI:   op = OP_LUI;   OPC_LB:   op = OP_LB;
        OPC_LH:   op = OP_LH;    OPC_LW:    op = OP_LW;    OPC_LBU:  op = OP_LBU;
        OPC_LHU:  op = OP_LHU;   OPC_SB:    op = OP_SB;    OPC_SH:   op = OP_SH;
        OPC_SW:   op = OP_SW;
        default:  op = OP_ILLEGAL;
      endcase
    end
  end

  always_comb begin
    dec            = '0;
    dec.opcode     = insn[31:26];
    dec.rs         = insn[25:21];
    dec.rt         = insn[20:16];
    dec.rd         = insn[15:11];
    dec.shamt      = insn[10:6];
    dec.funct      = insn[5:0];
    dec.op         = op;
    dec.illegal    = (op == OP_ILLEGAL);
    if (dec.illegal)                       dec.insn_class = CLASS_ILL;
    else if (insn[31:26] == OPC_SPECIAL)   dec.insn_class = CLASS_R;
    else if (op == OP_J || op == OP_JAL)   dec.insn_class = CLASS_J;
    else                                   dec.insn_class = CLASS_I;
    // Logical immediates are zero-extended; everything else sign-extends.
    if (insn[31:26] == OPC_ANDI || insn[31:26] == OPC_ORI || insn[31:26] == OPC_XORI) begin
      dec.imm_ext = {16'h0000, insn[15:0]};
    end else begin
      dec.imm_ext = sext_imm;
    end
    dec.br_target  = pc_plus4 + {sext_imm[29:0], 2'b00};
    dec.jmp_target = {pc_plus4[31:28], insn[25:0], 2'b00};
  end

endmodule

// File: rtl/mips_fetch_decode.sv
// MIPS-I front end: word-read PC generator and a registered one-stage instruction decoder.
module mips_fetch_decode
  import mips_pkg::*;
#(
  parameter logic [31:0] START_ADDRESS = START_ADDRESS_DEFAULT
) (
  input logic                 clock,
  input logic                 reset,
  input logic                 stall,
  mips_fetch_decode_if.master bus
);

  logic [31:0] pc_q;
  logic        dec_valid_q;
  logic [31:0] dec_pc_q;
  dec_t        dec_d, dec_q;

  mips_decoder u_decoder (
    .insn (bus.insn),
    .pc   (bus.pc_in),
    .dec  (dec_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= START_ADDRESS;
    end else if (!stall) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  // Fields hold their last decoded values while no new instruction arrives.
  always_ff @(posedge clock) begin
    if (reset) begin
      dec_valid_q <= 1'b0;
      dec_pc_q    <= '0;
      dec_q       <= '0;
    end else begin
      dec_valid_q <= bus.valid_insn;
      if (bus.valid_insn) begin
        dec_pc_q <= bus.pc_in;
        dec_q    <= dec_d;
      end
    end
  end

  assign bus.pc_out       = pc_q;
  assign bus.rw           = 1'b0;
  assign bus.acc_size_out = ACC_WORD;

  assign bus.dec_valid  = dec_valid_q;
  assign bus.dec_pc     = dec_pc_q;
  assign bus.opcode     = dec_q.opcode;
  assign bus.rs         = dec_q.rs;
  assign bus.rt         = dec_q.rt;
  assign bus.rd         = dec_q.rd;
  assign bus.shamt      = dec_q.shamt;
  assign bus.funct      = dec_q.funct;
  assign bus.imm_ext    = dec_q.imm_ext;
  assign bus.br_target  = dec_q.br_target;
  assign bus.jmp_target = dec_q.jmp_target;
  assign bus.op         = dec_q.op;
  assign bus.insn_class = dec_q.insn_class;
  assign bus.illegal    = dec_q.illegal;

endmodule

// File: tb/tb_mips_fetch_decode.sv
// Scoreboard bench for mips_fetch_decode: directed vectors, then random traffic checked
// against a table-driven reference decoder.
module tb_mips_fetch_decode;
  import mips_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [31:0] imm, br, jmp;
    op_e         op;
    logic [1:0]  cls;
    logic        ill;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic stall = 1'b0;

  mips_fetch_decode_if bus ();
  mips_fetch_decode_if bus2 ();

  mips_fetch_decode dut (
    .clock (clock),
    .reset (reset),
    .stall (stall),
    .bus   (bus)
  );

  // Second instance started near the top of the address space to exercise PC wrap.
  mips_fetch_decode #(.START_ADDRESS(32'hFFFF_FFF8)) dut_wrap (
    .clock (clock),
    .reset (reset),
    .stall (1'b0),
    .bus   (bus2)
  );

  always #5 clock = ~clock;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t hold;
  logic [31:0] pc_m, pc2_m;
  bit   started  = 0;
  bit   rst_flag = 0;

  op_e r_tab[int];
  op_e i_tab[int];
  int  legal_fn[$];
  int  legal_opc[$];

  function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void chk_rec(input string name, input exp_t act, input exp_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] p);
    exp_t e;
    logic [31:0] sx, nxt;
    e.pc = p;
    e.opcode = i[31:26]; e.rs = i[25:21]; e.rt = i[20:16]; e.rd = i[15:11];
    e.shamt = i[10:6]; e.funct = i[5:0];
    if (i == 32'd0) e.op = OP_NOP;
    else if (i[31:26] == 6'd0) e.op = r_tab.exists(int'(i[5:0])) ? r_tab[int'(i[5:0])] : OP_ILLEGAL;
    else if (i[31:26] == 6'd1) e.op = (i[20:16] == 5'd0) ? OP_BLTZ :
                                       (i[20:16] == 5'd1) ? OP_BGEZ : OP_ILLEGAL;
    else e.op = i_tab.exists(int'(i[31:26])) ? i_tab[int'(i[31:26])] : OP_ILLEGAL;
    e.ill = (e.op == OP_ILLEGAL);
    if (e.ill) e.cls = 2'd3;
    else if (i[31:26] == 6'd0) e.cls = 2'd0;
    else if (e.op == OP_J || e.op == OP_JAL) e.cls = 2'd2;
    else e.cls = 2'd1;
    sx = 32'($signed(i[15:0]));
    e.imm = (e.op inside {OP_ANDI, OP_ORI, OP_XORI}) ? {16'h0, i[15:0]} : sx;
    nxt = p + 32'd4;
    e.br = nxt + sx * 32'd4;
    e.jmp = (nxt & 32'hF000_0000) | ({6'd0, i[25:0]} * 32'd4);
    return e;
  endfunction

  function automatic void init_tables();
    r_tab[6'h00] = OP_SLL;  r_tab[6'h02] = OP_SRL;  r_tab[6'h03] = OP_SRA;  r_tab[6'h04] = OP_SLLV;
    r_tab[6'h06] = OP_SRLV; r_tab[6'h07] = OP_SRAV; r_tab[6'h08] = OP_JR;   r_tab[6'h09] = OP_JALR;
    r_tab[6'h10] = OP_MFHI; r_tab[6'h12] = OP_MFLO; r_tab[6'h18] = OP_MULT; r_tab[6'h19] = OP_MULTU;
    r_tab[6'h1a] = OP_DIV;  r_tab[6'h1b] = OP_DIVU; r_tab[6'h20] = OP_ADD;  r_tab[6'h21] = OP_ADDU;
    r_tab[6'h22] = OP_SUB;  r_tab[6'h23] = OP_SUBU; r_tab[6'h24] = OP_AND;  r_tab[6'h25] = OP_OR;
    r_tab[6'h26] = OP_XOR;  r_tab[6'h27] = OP_NOR;  r_tab[6'h2a] = OP_SLT;  r_tab[6'h2b] = OP_SLTU;
    i_tab[6'h02] = OP_J;    i_tab[6'h03] = OP_JAL;  i_tab[6'h04] = OP_BEQ;  i_tab[6'h05] = OP_BNE;
    i_tab[6'h06] = OP_BLEZ; i_tab[6'h07] = OP_BGTZ; i_tab[6'h08] = OP_ADDI; i_tab[6'h09] = OP_ADDIU;
    i_tab[6'h0a] = OP_SLTI; i_tab[6'h0b] = OP_SLTIU; i_tab[6'h0c] = OP_ANDI; i_tab[6'h0d] = OP_ORI;
    i_tab[6'h0e] = OP_XORI; i_tab[6'h0f] = OP_LUI;  i_tab[6'h20] = OP_LB;   i_tab[6'h21] = OP_LH;
    i_tab[6'h23] = OP_LW;   i_tab[6'h24] = OP_LBU;  i_tab[6'h25] = OP_LHU;  i_tab[6'h28] = OP_SB;
    i_tab[6'h29] = OP_SH;   i_tab[6'h2b] = OP_SW;
    foreach (r_tab[k]) legal_fn.push_back(k);
    foreach (i_tab[k]) legal_opc.push_back(k);
  endfunction

  // Apply inputs for one clock edge and update the reference state for that edge.
  task automatic cycle(input logic r, input logic s, input logic v,
                       input logic [31:0] i, input logic [31:0] p);
    reset = r; stall = s;
    bus.valid_insn = v; bus.insn = i; bus.pc_in = p;
    @(posedge clock);
    if (r) begin
      pc_m = START_ADDRESS_DEFAULT;
      pc2_m = 32'hFFFF_FFF8;
      sb.delete();
      rst_flag = 1;
      started = 1;
    end else begin
      if (!s) pc_m = pc_m + 32'd4;
      pc2_m = pc2_m + 32'd4;
      if (v) sb.push_back(model(i, p));
    end
    #2;
  endtask

  function automatic logic [31:0] rand_insn();
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: return {6'd0, 20'($urandom), 6'(legal_fn[$urandom_range(0, legal_fn.size() - 1)])};
      2: return {6'(legal_opc[$urandom_range(0, legal_opc.size() - 1)]), 26'($urandom)};
      3: return {6'd1, 5'($urandom), 5'($urandom_range(0, 2)), 16'($urandom)};
      default: return ($urandom_range(0, 1) == 0) ? 32'd0 : {6'd0, 20'($urandom), 6'($urandom)};
    endcase
  endfunction

  // Monitor: compares fetch outputs every cycle and pops the scoreboard on dec_valid.
  initial begin
    exp_t act;
    hold = '0;
    forever begin
      @(negedge clock);
      if (started) begin
        chk32("pc_out", bus.pc_out, pc_m);
        chk32("pc_out_wrap", bus2.pc_out, pc2_m);
        chk32("rw_acc", {29'd0, bus.rw, bus.acc_size_out}, {29'd0, 1'b0, ACC_WORD});
        act = '{pc: bus.dec_pc, opcode: bus.opcode, rs: bus.rs, rt: bus.rt, rd: bus.rd,
                shamt: bus.shamt, funct: bus.funct, imm: bus.imm_ext, br: bus.br_target,
                jmp: bus.jmp_target, op: bus.op, cls: bus.insn_class, ill: bus.illegal};
        if (rst_flag) begin
          rst_flag = 0;
          hold = '0;
          hold.op = OP_NOP;
          chk32("dec_valid_reset", {31'd0, bus.dec_valid}, 32'd0);
          chk_rec("dec_reset", act, hold);
        end else if (bus.dec_valid) begin
          if (sb.size() == 0) begin
            chk32("dec_spurious", 32'd1, 32'd0);
          end else begin
            hold = sb.pop_front();
            chk_rec("dec_fields", act, hold);
          end
        end else begin
          if (sb.size() != 0) begin
            chk32("dec_missing", 32'(sb.size()), 32'd0);
            hold = sb.pop_front();
          end
          chk_rec("dec_hold", act, hold);
        end
      end
    end
  end

  initial begin
    init_tables();
    bus.valid_insn = 0; bus.insn = '0; bus.pc_in = '0;
    bus2.valid_insn = 0; bus2.insn = '0; bus2.pc_in = '0;
    @(negedge clock);

    cycle(1, 0, 0, 32'h0, 32'h0);
    chk32("reset_pc", bus.pc_out, 32'h8002_0000);
    chk32("reset_dec_valid", {31'd0, bus.dec_valid}, 32'd0);

    repeat (2) cycle(0, 0, 0, 32'h0, 32'h0);
    chk32("wrap_to_zero", bus2.pc_out, 32'h0000_0000);
    cycle(0, 0, 0, 32'h0, 32'h0);
    chk32("pc_3_steps", bus.pc_out, 32'h8002_000C);
    repeat (2) cycle(0, 1, 0, 32'h0, 32'h0);
    chk32("pc_stalled", bus.pc_out, 32'h8002_000C);

    cycle(0, 1, 1, 32'h27BD_FFF0, 32'h8002_0004);
    chk32("addiu_op", 32'(bus.op), 32'(OP_ADDIU));
    chk32("addiu_rs_rt", {22'd0, bus.rs, bus.rt}, {22'd0, 5'd29, 5'd29});
    chk32("addiu_imm", bus.imm_ext, 32'hFFFF_FFF0);
    chk32("addiu_class_valid", {29'd0, bus.insn_class, bus.dec_valid}, {29'd0, 2'd1, 1'b1});

    cycle(0, 0, 1, 32'h1040_0003, 32'h8002_0000);
    chk32("beq_op", 32'(bus.op), 32'(OP_BEQ));
    chk32("beq_rs_rt", {22'd0, bus.rs, bus.rt}, {22'd0, 5'd2, 5'd0});
    chk32("beq_target", bus.br_target, 32'h8002_0010);
    cycle(0, 0, 1, 32'h03E0_0008, 32'h8002_0008);
    chk32("jr_op_rs_class", {19'd0, 6'(bus.op), bus.rs, bus.insn_class},
          {19'd0, 6'(OP_JR), 5'd31, 2'd0});

    cycle(0, 0, 1, 32'h0C00_800A, 32'h8002_0010);
    chk32("jal_op", 32'(bus.op), 32'(OP_JAL));
    chk32("jal_target", bus.jmp_target, 32'h8002_0028);
    chk32("jal_class", {30'd0, bus.insn_class}, 32'd2);
    cycle(0, 0, 1, 32'h3421_8000, 32'h8002_0014);
    chk32("ori_op", 32'(bus.op), 32'(OP_ORI));
    chk32("ori_imm", bus.imm_ext, 32'h0000_8000);

    cycle(0, 0, 1, 32'hFC00_0000, 32'h8002_0018);
    chk32("illegal_flag_class", {29'd0, bus.illegal, bus.insn_class}, {29'd0, 1'b1, 2'd3});
    cycle(0, 0, 0, 32'h1234_5678, 32'h0);
    chk32("idle_valid", {31'd0, bus.dec_valid}, 32'd0);
    chk32("idle_held_op", 32'(bus.op), 32'(OP_ILLEGAL));
    cycle(1, 0, 1, 32'h27BD_FFF0, 32'h8002_0004);
    chk32("reset_wins_valid", {31'd0, bus.dec_valid}, 32'd0);
    chk32("reset_wins_op_ill", {25'd0, 6'(bus.op), bus.illegal}, {25'd0, 6'(OP_NOP), 1'b0});

    for (int n = 0; n < 500; n++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) != 0), rand_insn(), $urandom);
    end

    repeat (2) cycle(0, 0, 0, 32'h0, 32'h0);
    chk32("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
